// File: rtl/fpalu_arbiter.sv
// fpalu_arbiter: round-robin issue arbiter with burst lock for the shared FPALU.
// Tags each issue and routes alu_y back to its owner LAT enabled cycles later.
module fpalu_arbiter #(
  parameter int N_REQ = 2,
  parameter int LAT   = 4,
  parameter int DW    = 29
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_en,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [2*N_REQ-1:0]  req_op,
  input  logic [DW*N_REQ-1:0] req_a,
  input  logic [DW*N_REQ-1:0] req_b,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [1:0]          alu_op,
  input  logic [DW-1:0]       alu_y,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_y,
  output logic                busy,
  output logic                err_op
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;

  typedef logic [IW-1:0] id_t;
  typedef enum logic {S_IDLE, S_LOCK} state_e;

  state_e st_q, st_d;
  id_t    rr_q, rr_d;
  id_t    lk_q, lk_d;

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic          err_q, err_d;

  // Stage 0 rides with the operand register; stage LAT is the tail.
  logic [LAT:0]         tv_q, tv_d;
  logic [LAT:0][IW-1:0] tid_q, tid_d;

  logic          gnt_v;
  id_t           gnt_id;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_b;
  logic [1:0]    sel_op;
  logic          sel_lock;
  logic          sel_last;

  function automatic id_t nxt(input id_t i, input int k);
    int s = int'(i) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return id_t'(s);
  endfunction

  // Lowest rotated offset wins, so iterate downward and let it overwrite.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    if (alu_en) begin
      if (st_q == S_LOCK) begin
        gnt_v  = req_valid[lk_q];
        gnt_id = lk_q;
      end else begin
        for (int k = N_REQ-1; k >= 0; k--) begin
          if (req_valid[nxt(rr_q, k)]) begin
            gnt_v  = 1'b1;
            gnt_id = nxt(rr_q, k);
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    req_ready[gnt_id] = gnt_v;
  end

  assign sel_a    = req_a[int'(gnt_id)*DW +: DW];
  assign sel_b    = req_b[int'(gnt_id)*DW +: DW];
  assign sel_op   = req_op[int'(gnt_id)*2 +: 2];
  assign sel_lock = req_lock[gnt_id];
  assign sel_last = req_last[gnt_id];

  always_comb begin
    st_d  = st_q;
    rr_d  = rr_q;
    lk_d  = lk_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    err_d = err_q;
    tv_d  = tv_q;
    tid_d = tid_q;
    if (gnt_v) begin
      a_d  = sel_a;
      b_d  = sel_b;
      op_d = sel_op;
      if (!sel_op[1]) err_d = 1'b1;
      unique case (st_q)
        S_LOCK: begin
          if (sel_last) begin
            st_d = S_IDLE;
            rr_d = nxt(gnt_id, 1);
          end
        end
        default: begin
          if (sel_lock && !sel_last) begin
            st_d = S_LOCK;
            lk_d = gnt_id;
          end else begin
            rr_d = nxt(gnt_id, 1);
          end
        end
      endcase
    end
    if (alu_en) begin
      tv_d  = {tv_q[LAT-1:0], gnt_v};
      tid_d = {tid_q[LAT-1:0], gnt_id};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      rr_q  <= '0;
      lk_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      err_q <= 1'b0;
      tv_q  <= '0;
      tid_q <= '0;
    end else begin
      st_q  <= st_d;
      rr_q  <= rr_d;
      lk_q  <= lk_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      err_q <= err_d;
      tv_q  <= tv_d;
      tid_q <= tid_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_valid[tid_q[LAT]] = tv_q[LAT] & alu_en;
  end

  assign rsp_y  = alu_y;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign err_op = err_q;
  assign busy   = (|tv_q) | (st_q == S_LOCK);

endmodule
